// File: rtl/rf_wb_writer.sv
// Register-file write arbiter: clears all 32 registers after reset, then merges pipeline
// writeback and debug-monitor writes onto a single registered write port.
module rf_wb_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_wen,
    input  logic [4:0]  wb_adr,
    input  logic [31:0] wb_data,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_adr,
    input  logic [31:0] dbg_data,
    output logic        dbg_ack,
    output logic        ram_wen,
    output logic [4:0]  ram_wadr,
    output logic [31:0] ram_wdata,
    output logic        init_busy,
    output logic        wb_drop_err
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t     state;
    logic [4:0] sweep_cnt;
    logic       dbg_take;

    // A held request must not be re-served in its own ack cycle; pipeline always wins.
    always_comb begin
        dbg_take = 1'b0;
        dbg_take = dbg_req && !dbg_ack && !wb_wen;
    end

    assign init_busy = (state == INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            sweep_cnt   <= '0;
            ram_wen     <= 1'b0;
            ram_wadr    <= '0;
            ram_wdata   <= '0;
            dbg_ack     <= 1'b0;
            wb_drop_err <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    ram_wen   <= 1'b1;
                    ram_wadr  <= sweep_cnt;
                    ram_wdata <= '0;
                    dbg_ack   <= 1'b0;
                    sweep_cnt <= sweep_cnt + 5'd1;
                    if (wb_wen) begin
                        wb_drop_err <= 1'b1;
                    end
                    if (sweep_cnt == 5'd31) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    ram_wen <= 1'b0;
                    dbg_ack <= 1'b0;
                    // Writes to x0 are swallowed: no enable, address/data keep their old values.
                    if (wb_wen) begin
                        if (wb_adr != 5'd0) begin
                            ram_wen   <= 1'b1;
                            ram_wadr  <= wb_adr;
                            ram_wdata <= wb_data;
                        end
                    end else if (dbg_take) begin
                        dbg_ack <= 1'b1;
                        if (dbg_adr != 5'd0) begin
                            ram_wen   <= 1'b1;
                            ram_wadr  <= dbg_adr;
                            ram_wdata <= dbg_data;
                        end
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wb_writer.sv
// Scoreboard bench for rf_wb_writer: directed scenarios followed by random traffic,
// with per-cycle expectations produced by a transaction-level model.
module tb_rf_wb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_wen;
    logic [4:0]  wb_adr;
    logic [31:0] wb_data;
    logic        dbg_req;
    logic [4:0]  dbg_adr;
    logic [31:0] dbg_data;
    logic        dbg_ack;
    logic        ram_wen;
    logic [4:0]  ram_wadr;
    logic [31:0] ram_wdata;
    logic        init_busy;
    logic        wb_drop_err;

    rf_wb_writer dut (
        .clk         (clk),
        .rst         (rst),
        .wb_wen      (wb_wen),
        .wb_adr      (wb_adr),
        .wb_data     (wb_data),
        .dbg_req     (dbg_req),
        .dbg_adr     (dbg_adr),
        .dbg_data    (dbg_data),
        .dbg_ack     (dbg_ack),
        .ram_wen     (ram_wen),
        .ram_wadr    (ram_wadr),
        .ram_wdata   (ram_wdata),
        .init_busy   (init_busy),
        .wb_drop_err (wb_drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  adr;
        logic [31:0] data;
        logic        ack;
        logic        busy;
        logic        drop;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: next address to clear (32 = sweep finished), sticky drop,
    // last visible write port contents, and whether ack is visible this cycle.
    int          m_idx  = 0;
    logic        m_drop = 1'b0;
    logic [4:0]  m_adr  = '0;
    logic [31:0] m_data = '0;
    logic        m_ack  = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    // Predict what the outputs show after the next rising edge, then wait one cycle.
    task automatic step();
        exp_t e;
        e.wen = 1'b0;
        e.ack = 1'b0;
        if (rst) begin
            m_idx  = 0;
            m_drop = 1'b0;
            m_adr  = '0;
            m_data = '0;
        end else if (m_idx < 32) begin
            e.wen  = 1'b1;
            m_adr  = 5'(m_idx);
            m_data = '0;
            if (wb_wen) m_drop = 1'b1;
            m_idx++;
        end else if (wb_wen) begin
            if (wb_adr != 0) begin
                e.wen  = 1'b1;
                m_adr  = wb_adr;
                m_data = wb_data;
            end
        end else if (dbg_req && !m_ack) begin
            e.ack = 1'b1;
            if (dbg_adr != 0) begin
                e.wen  = 1'b1;
                m_adr  = dbg_adr;
                m_data = dbg_data;
            end
        end
        e.adr  = m_adr;
        e.data = m_data;
        e.busy = (m_idx < 32);
        e.drop = m_drop;
        m_ack  = e.ack;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(int unsigned n);
        wb_wen = 1'b0;
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    // Hold the debug request until the model shows its ack, keep it through that cycle, then drop it.
    task automatic finish_dbg(int unsigned bound);
        int unsigned k = 0;
        wb_wen = 1'b0;
        while (!m_ack && k < bound) begin
            step();
            k++;
        end
        if (!m_ack) begin
            n_fail++;
            $display("FAIL dbg_handshake: got no ack expected ack within %0d cycles", bound);
        end
        step();
        dbg_req = 1'b0;
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ram_wen",     32'(ram_wen),     32'(e.wen));
                chk("ram_wadr",    32'(ram_wadr),    32'(e.adr));
                chk("ram_wdata",   ram_wdata,        e.data);
                chk("dbg_ack",     32'(dbg_ack),     32'(e.ack));
                chk("init_busy",   32'(init_busy),   32'(e.busy));
                chk("wb_drop_err", 32'(wb_drop_err), 32'(e.drop));
            end
        end
    end

    initial begin
        logic hold_one;
        rst = 1'b1; wb_wen = 1'b0; wb_adr = '0; wb_data = '0;
        dbg_req = 1'b0; dbg_adr = '0; dbg_data = '0;
        step();
        step();
        rst = 1'b0;

        // Clear sweep then a single pipeline write.
        idle(34);
        wb_wen = 1'b1; wb_adr = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        idle(2);

        // Collision: held debug request loses to three pipeline writes.
        dbg_req = 1'b1; dbg_adr = 5'd7; dbg_data = 32'h12345678;
        wb_wen = 1'b1; wb_adr = 5'd3;
        wb_data = 32'hA0A0A0A0; step();
        wb_data = 32'hB1B1B1B1; step();
        wb_data = 32'hC2C2C2C2; step();
        finish_dbg(10);
        idle(2);

        // x0 protection on both paths.
        wb_wen = 1'b1; wb_adr = 5'd0; wb_data = 32'hFFFFFFFF;
        step();
        idle(1);
        dbg_req = 1'b1; dbg_adr = 5'd0; dbg_data = 32'h55555555;
        finish_dbg(10);
        idle(2);

        // Pipeline write dropped at sweep cycle 10; flag stays set until reset.
        rst = 1'b1; step(); rst = 1'b0;
        idle(10);
        wb_wen = 1'b1; wb_adr = 5'd9; wb_data = 32'h0BADF00D;
        step();
        idle(30);
        wb_wen = 1'b1; wb_adr = 5'd12; wb_data = 32'h00C0FFEE;
        step();
        idle(3);

        // Reset at sweep cycle 20 with a debug request pending across it.
        rst = 1'b1; step(); rst = 1'b0;
        dbg_req = 1'b1; dbg_adr = 5'd9; dbg_data = 32'hCAFEF00D;
        idle(20);
        rst = 1'b1; step(); rst = 1'b0;
        finish_dbg(40);
        idle(2);

        // Random traffic with occasional resets and held-through-ack requests.
        hold_one = 1'b0;
        for (int unsigned i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            wb_wen  = ($urandom_range(0, 9) < 4);
            wb_adr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_data = $urandom;
            if (hold_one) begin
                dbg_req  = 1'b0;
                hold_one = 1'b0;
            end else if (dbg_req && m_ack) begin
                hold_one = 1'b1;
            end else if (!dbg_req && $urandom_range(0, 4) == 0) begin
                dbg_req  = 1'b1;
                dbg_adr  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                dbg_data = $urandom;
            end
            step();
        end
        rst = 1'b0; wb_wen = 1'b0; dbg_req = 1'b0;

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_writer.md
RF_WB_WRITER -- requirements
Module: rf_wb_writer

Interface
REQ-001 The block SHALL have no parameters; register count is fixed at 32 and data width at 32.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 wb_wen  input  1  pipeline writeback request, valid for one cycle.
REQ-005 wb_adr  input  5  pipeline destination register.
REQ-006 wb_data  input  32  pipeline writeback data.
REQ-007 dbg_req  input  1  debug-monitor write request, held high until dbg_ack.
REQ-008 dbg_adr  input  5  debug destination register, stable while dbg_req is high.
REQ-009 dbg_data  input  32  debug write data, stable while dbg_req is high.
REQ-010 dbg_ack  output  1  one-cycle pulse marking completion of the debug request.
REQ-011 ram_wen  output  1  register-file write enable.
REQ-012 ram_wadr  output  5  register-file write address.
REQ-013 ram_wdata  output  32  register-file write data.
REQ-014 init_busy  output  1  high while the register-file clear sweep runs; the pipeline stalls on it.
REQ-015 wb_drop_err  output  1  sticky flag: a pipeline write arrived during the sweep and was discarded.

Function
REQ-016 dbg_ack, ram_wen, ram_wadr, ram_wdata and wb_drop_err SHALL be driven from flops; none is a combinational function of the current inputs.
REQ-017 FSM states: INIT and RUN; rst forces INIT with sweep counter = 0.
REQ-018 INIT: each cycle, register ram_wen=1, ram_wadr=counter, ram_wdata=0; increment the counter.
REQ-019 INIT: after the cycle that issues address 31, move to RUN; the sweep is exactly 32 cycles with ram_wen high.
REQ-020 init_busy SHALL equal 1 exactly while the state is INIT; it falls in the same cycle the state becomes RUN.
REQ-021 INIT: wb_wen=1 SHALL be discarded and wb_drop_err set to 1; wb_drop_err is cleared only by rst.
REQ-022 INIT: dbg_req SHALL NOT be served; it stays pending and is not acknowledged.
REQ-023 RUN: latency 1; a request accepted in cycle N appears on ram_wen/ram_wadr/ram_wdata in cycle N+1.
REQ-024 RUN priority: wb_wen has priority over dbg_req; a debug request is served only in a cycle with wb_wen=0.
REQ-025 Accepting a debug request SHALL produce, one cycle later, the ram_* write and a single-cycle dbg_ack=1.
REQ-026 In the cycle dbg_ack is high, the block SHALL NOT accept dbg_req again; this prevents double-service of a held request.
REQ-027 x0 protection in RUN: any accepted write to address 0 SHALL produce ram_wen=0.
REQ-028 A debug write to x0 SHALL still be acknowledged.
REQ-029 With no accepted request, ram_wen SHALL be 0; ram_wadr and ram_wdata hold their previous values.
REQ-030 The write port is single-port with one write per cycle; simultaneous wb_wen and dbg_req SHALL never cause two writes or a lost pipeline write.

Reset
REQ-031 On rst the block SHALL set the state to INIT, the sweep counter to 0, and ram_wen=0, ram_wadr=0, ram_wdata=0, dbg_ack=0 and wb_drop_err=0; init_busy=1 follows from the INIT state.
REQ-032 The sweep SHALL start in the first cycle after rst deasserts.
REQ-033 rst asserted mid-sweep or mid-debug-handshake SHALL abort the operation and restart the sweep from 0; a pending debug request is not acknowledged.

Verification
REQ-034 Clear sweep: release rst -> 32 consecutive cycles of ram_wen=1 with addresses 0..31 and data 0; then init_busy=0 and ram_wen=0.
REQ-035 Pipeline write: in RUN, wb_wen=1, wb_adr=5, wb_data=0xDEADBEEF -> next cycle ram_wen=1, ram_wadr=5, ram_wdata=0xDEADBEEF.
REQ-036 Collision: dbg_req (adr 7, 0x12345678) held while wb_wen=1 for 3 consecutive cycles (adr 3) -> three x3 writes, then one x7 write with dbg_ack pulsed once in that same cycle.
REQ-037 x0 protection: wb_wen to x0 -> ram_wen stays 0; debug write to x0 -> dbg_ack=1 and ram_wen=0.
REQ-038 Drop during init: wb_wen=1 at sweep cycle 10 -> sweep unaffected; wb_drop_err=1 and it stays 1 until rst.
REQ-039 Reset mid-sweep: rst at sweep cycle 20 -> sweep restarts at address 0 and runs a full 32 cycles; a debug request pending through the reset is acknowledged only after the new sweep completes.
